seq_divider16x8: RTL and testbench

- Multi-cycle restoring divider; the inverse datapath of the 8x8 Vedic multiplier.
- Takes a 16-bit dividend (a product-width operand) and an 8-bit divisor, and returns a 16-bit quotient, an 8-bit remainder and a divide-by-zero flag.
- Processes one quotient bit per cycle.
- Uses valid/ready handshakes on the input and output sides so it can sit in a pipeline next to the multiplier.

---
 rtl/seq_divider16x8.sv | 115 +++++++++++
 tb/tb_seq_divider16x8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider16x8.sv
// rtl/seq_divider16x8.sv - multi-cycle unsigned restoring divider with valid/ready handshakes
module seq_divider16x8 #(
  parameter int N = 16,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  q_sh;
  logic [M-1:0]  dvs;
  logic [M-1:0]  r;

  logic [M:0]    t;
  logic          ge;
  logic [M-1:0]  r_next;
  logic [N-1:0]  q_next;

  // One restoring step: shift the next dividend bit into the partial remainder,
  // trial-subtract at M+1 bits, keep the difference only when it did not borrow.
  // The kept remainder is always below the divisor, so it fits back in M bits.
  always_comb begin
    t      = {r, q_sh[N-1]};
    ge     = (t >= {1'b0, dvs});
    r_next = ge ? M'(t - {1'b0, dvs}) : t[M-1:0];
    q_next = {q_sh[N-2:0], ge};
  end

  // Control FSM and datapath registers; result registers load only on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      q_sh        <= '0;
      dvs         <= '0;
      r           <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          if (in_valid && in_ready) begin
            q_sh     <= dividend;
            dvs      <= divisor;
            r        <= '0;
            cnt      <= CW'(N - 1);
            in_ready <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend[M-1:0];
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          q_sh <= q_next;
          r    <= r_next;
          if (cnt == '0) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16x8.sv
// tb/tb_seq_divider16x8.sv - directed and random self-checking bench for seq_divider16x8
module tb_seq_divider16x8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_divider16x8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // waits (bounded) for in_ready, then presents one operation for exactly one edge
  task automatic start_op(input logic [15:0] dd, input logic [7:0] dv, input string tag);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_ready"}, in_ready, 1);
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // counts edges from the acceptance edge (inclusive) to the edge raising out_valid
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [15:0] dd, input logic [7:0] dv, input logic [15:0] eq,
                        input logic [7:0] er, input logic ez, input int elat, input string tag);
    int lat;
    out_ready = 1'b1;
    start_op(dd, dv, tag);
    wait_valid(lat);
    check({tag, "_lat"}, lat, elat);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, div_by_zero, ez);
    @(posedge clk); #1;
    check({tag, "_ovalid_clr"}, out_valid, 0);
    check({tag, "_iready_set"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          w;
    bit          seen;
    bit          got;
    logic [15:0] dd, eq, cq;
    logic [7:0]  dv, er, cr;
    logic        ez, cz;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_iready", in_ready, 1);
    check("rst_ovalid", out_valid, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'h7530, 8'h96, 16'h00C8, 8'h00, 1'b0, 17, "mul_inv");
    run_op(16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, 17, "rem_case");
    run_op(16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 17, "max_ops");
    run_op(16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 17, "div_one");
    run_op(16'h0005, 8'h09, 16'h0000, 8'h05, 1'b0, 17, "dd_lt_dv");
    run_op(16'h0000, 8'h37, 16'h0000, 8'h00, 1'b0, 17, "dd_zero");
    run_op(16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1, 1,  "dbz");
    run_op(16'h0010, 8'h04, 16'h0004, 8'h00, 1'b0, 17, "after_dbz");

    // back-pressure: result must hold while out_ready is low and a new request is ignored
    out_ready = 1'b0;
    start_op(16'h7530, 8'h96, "bp");
    wait_valid(lat);
    check("bp_lat", lat, 17);
    dividend = 16'h1111;
    divisor  = 8'h11;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_ovalid", out_valid, 1);
      check("bp_q", quotient, 16'h00C8);
      check("bp_r", remainder, 8'h00);
      check("bp_iready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_ovalid", out_valid, 0);
    check("bp_hs_iready", in_ready, 1);
    @(posedge clk); #1;
    check("bp_idle_iready", in_ready, 1);
    check("bp_idle_ovalid", out_valid, 0);
    check("bp_idle_q_held", quotient, 16'h00C8);

    // reset during CALC discards the operation
    out_ready = 1'b1;
    start_op(16'h03E8, 8'h07, "mid_rst");
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_iready", in_ready, 1);
    check("mid_rst_ovalid", out_valid, 0);
    check("mid_rst_q", quotient, 0);
    check("mid_rst_r", remainder, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", seen, 0);
    run_op(16'h0064, 8'h0A, 16'h000A, 8'h00, 1'b0, 17, "post_rst");

    // random regression with stalls and forced zero divisors
    for (int i = 0; i < 2000; i++) begin
      dd = 16'($urandom);
      dv = (i % 8 == 0) ? 8'h00 : 8'($urandom);
      if (dv == 8'h00) begin
        eq = 16'hFFFF;
        er = dd[7:0];
        ez = 1'b1;
      end else begin
        eq = dd / {8'h00, dv};
        er = 8'(dd % {8'h00, dv});
        ez = 1'b0;
      end
      out_ready = 1'b0;
      start_op(dd, dv, "rnd");
      got = 1'b0;
      cq  = '0;
      cr  = '0;
      cz  = 1'b0;
      w   = 0;
      while (!got && w < 200) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          cq  = quotient;
          cr  = remainder;
          cz  = div_by_zero;
          got = 1'b1;
        end
        @(posedge clk); #1;
        w++;
      end
      out_ready = 1'b0;
      check("rnd_got", got, 1);
      check("rnd_result", {cq, cr, cz}, {eq, er, ez});
      if (dv != 8'h00)
        check("rnd_invariant",
              ((32'(cq) * 32'(dv) + 32'(cr)) == 32'(dd)) && (cr < dv), 1);
      check("rnd_single", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
